// File: rtl/tfhe_axil_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tfhe_axil_master_pkg
// Brief   : FSM state encoding and AXI response codes for tfhe_axil_master.
// Rev     : 1.0
// ============================================================================
package tfhe_axil_master_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_e;

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;
   localparam logic [1:0] c_RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/tfhe_axil_master.sv
`default_nettype none
// ============================================================================
// Module  : tfhe_axil_master
// Brief   : Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Rev     : 1.0
// ============================================================================
module tfhe_axil_master
   import tfhe_axil_master_pkg::*;
#(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 6
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETN,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   localparam int c_STRB_W = C_M_AXI_DATA_WIDTH / 8;

   state_e                          state_q, state_d;
   logic                            cmd_ready_q, cmd_ready_d;
   logic                            awvalid_q, awvalid_d;
   logic                            wvalid_q, wvalid_d;
   logic                            bready_q, bready_d;
   logic                            arvalid_q, arvalid_d;
   logic                            rready_q, rready_d;
   logic                            aw_done_q, aw_done_d;
   logic                            w_done_q, w_done_d;
   logic                            rsp_valid_q, rsp_valid_d;
   logic                            rsp_write_q, rsp_write_d;
   logic [1:0]                      rsp_resp_q, rsp_resp_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [c_STRB_W-1:0]             wstrb_q, wstrb_d;

   logic w_aw_fire, w_w_fire;

   assign w_aw_fire = awvalid_q && M_AXI_AWREADY;
   assign w_w_fire  = wvalid_q && M_AXI_WREADY;

   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (cmd_write) begin
                  state_d   = WR_REQ;
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  wstrb_d   = cmd_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_REQ;
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
               end
            end
         end
         // AW and W complete independently; leave only when both have fired.
         WR_REQ: begin
            if (w_aw_fire) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_w_fire) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || w_aw_fire) && (w_done_q || w_w_fire)) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (bready_q && M_AXI_BVALID) begin
               state_d     = RSP;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_resp_d  = M_AXI_BRESP;
               rsp_rdata_d = '0;
            end
         end
         RD_REQ: begin
            if (arvalid_q && M_AXI_ARREADY) begin
               state_d   = RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         RD_DATA: begin
            if (rready_q && M_AXI_RVALID) begin
               state_d     = RSP;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_resp_d  = M_AXI_RRESP;
               rsp_rdata_d = M_AXI_RDATA;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase

      // Registered copy of (state==IDLE) so it stays low while held in reset.
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_resp_q  <= c_RESP_OKAY;
         rsp_rdata_q <= '0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_write     = rsp_write_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_tfhe_axil_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_tfhe_axil_master
// Brief   : Directed bench for tfhe_axil_master against a delay-configurable slave.
// Rev     : 1.0
// ============================================================================
module tb_tfhe_axil_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [5:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [5:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   tfhe_axil_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(6)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // Slave model: each READY rises after its VALID has waited *_dly cycles.
   int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  b_resp_k = 2'b00, r_resp_k = 2'b00;
   int          aw_wait, w_wait, ar_wait, bcnt, rcnt;
   logic        aw_got, w_got, bpend, rpend;
   logic [5:0]  s_awaddr, s_araddr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic [31:0] mem [16];
   logic        aw_hs, w_hs;
   logic [5:0]  e_addr;
   logic [31:0] e_data;
   logic [3:0]  e_strb;

   assign awready = awvalid && (aw_wait >= aw_dly);
   assign wready  = wvalid && (w_wait >= w_dly);
   assign arready = arvalid && (ar_wait >= ar_dly);
   assign bvalid  = bpend && (bcnt == 0);
   assign rvalid  = rpend && (rcnt == 0);
   assign bresp   = b_resp_k;
   assign rresp   = r_resp_k;
   assign rdata   = mem[s_araddr[5:2]];
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign e_addr  = aw_hs ? awaddr : s_awaddr;
   assign e_data  = w_hs ? wdata : s_wdata;
   assign e_strb  = w_hs ? wstrb : s_wstrb;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_wait <= 0; w_wait <= 0; ar_wait <= 0; bcnt <= 0; rcnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0; rpend <= 1'b0;
         s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      end else begin
         aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
         w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
         ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
         if (aw_hs) begin aw_got <= 1'b1; s_awaddr <= awaddr; end
         if (w_hs) begin w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
         if (!bpend && (aw_got || aw_hs) && (w_got || w_hs)) begin
            bpend <= 1'b1;
            bcnt  <= b_dly;
            for (int b = 0; b < 4; b++)
               if (e_strb[b]) mem[e_addr[5:2]][b*8 +: 8] <= e_data[b*8 +: 8];
         end
         if (bvalid && bready) begin
            bpend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
         end else if (bpend && bcnt != 0) begin
            bcnt <= bcnt - 1;
         end
         if (arvalid && arready) begin
            rpend <= 1'b1; rcnt <= r_dly; s_araddr <= araddr;
         end
         if (rvalid && rready) rpend <= 1'b0;
         else if (rpend && rcnt != 0) rcnt <= rcnt - 1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Presents a command in cycle 0; returns at the negedge of cycle 1.
   task automatic send(input logic wr, input logic [5:0] a, input logic [31:0] d);
      chk("cmd_ready_before_send", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = 4'hF;
      step();
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
   endtask

   task automatic wait_rsp(input int start, output int cyc);
      cyc = start;
      while (!rsp_valid && cyc < 40) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      int c;
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      step(); step();
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      chk("rst_rsp", {rsp_write, rsp_resp, rsp_rdata[15:0]}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_awaddr", {awaddr, araddr}, 0);
      rst_n = 1'b1;
      step();
      chk("cmd_ready_after_release", cmd_ready, 1);

      // Zero-wait write: AW/W at 1, BREADY at 2, rsp at 3.
      send(1'b1, 6'h08, 32'h0000_1234);
      chk("wr_c1_awvalid", awvalid, 1);
      chk("wr_c1_wvalid", wvalid, 1);
      chk("wr_c1_awaddr", awaddr, 32'h08);
      chk("wr_c1_prot", {awprot, arprot}, 0);
      chk("wr_c1_wdata", {wdata}, 32'h1234);
      chk("wr_c1_cmd_ready", cmd_ready, 0);
      step();
      chk("wr_c2_awvalid", {awvalid, wvalid}, 0);
      chk("wr_c2_bready", bready, 1);
      step();
      chk("wr_c3_rsp_valid", rsp_valid, 1);
      chk("wr_c3_rsp_resp", rsp_resp, 0);
      chk("wr_c3_rsp_write", rsp_write, 1);
      chk("wr_c3_rsp_rdata", rsp_rdata, 0);
      step();
      chk("wr_c4_rsp_valid", rsp_valid, 0);
      chk("wr_c4_cmd_ready", cmd_ready, 1);
      chk("wr_slave_reg2", mem[2], 32'h1234);

      // WREADY held off until cycle 4, AWREADY immediate.
      w_dly = 3;
      send(1'b1, 6'h14, 32'hDEAD_BEEF);
      chk("ww_c1_valids", {awvalid, wvalid}, 2'b11);
      step();
      chk("ww_c2_valids", {awvalid, wvalid}, 2'b01);
      chk("ww_c2_bready", bready, 0);
      step();
      chk("ww_c3_wvalid", wvalid, 1);
      chk("ww_c3_wdata", wdata, 32'hDEAD_BEEF);
      chk("ww_c3_bready", bready, 0);
      step();
      chk("ww_c4_wvalid", wvalid, 1);
      chk("ww_c4_wdata", wdata, 32'hDEAD_BEEF);
      chk("ww_c4_bready", bready, 0);
      step();
      chk("ww_c5_wvalid", wvalid, 0);
      chk("ww_c5_bready", bready, 1);
      step();
      chk("ww_c6_rsp_valid", rsp_valid, 1);
      step();
      w_dly = 0;

      // Read with RVALID delayed two cycles after the AR handshake.
      r_dly = 2;
      send(1'b0, 6'h14, 32'h0);
      chk("rd_c1_arvalid", arvalid, 1);
      chk("rd_c1_araddr", araddr, 32'h14);
      chk("rd_c1_awvalid", awvalid, 0);
      step();
      chk("rd_c2_arvalid", arvalid, 0);
      chk("rd_c2_rready", rready, 1);
      wait_rsp(2, c);
      chk("rd_latency", c, 5);
      chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("rd_rsp_write", rsp_write, 0);
      chk("rd_rsp_resp", rsp_resp, 0);
      step();
      chk("rd_rready_after", rready, 0);
      r_dly = 0;

      // SLVERR write with rsp_ready held low for 4 cycles.
      b_resp_k  = 2'b10;
      rsp_ready = 1'b0;
      send(1'b1, 6'h20, 32'h0000_00A5);
      step(); step();
      for (int i = 0; i < 4; i++) begin
         chk("slv_hold_rsp_valid", rsp_valid, 1);
         chk("slv_hold_resp", rsp_resp, 2'b10);
         chk("slv_hold_cmd_ready", cmd_ready, 0);
         chk("slv_hold_rdata", rsp_rdata, 0);
         step();
      end
      rsp_ready = 1'b1;
      chk("slv_c7_rsp_valid", rsp_valid, 1);
      step();
      chk("slv_c8_rsp_valid", rsp_valid, 0);
      chk("slv_c8_cmd_ready", cmd_ready, 1);
      b_resp_k = 2'b00;

      // Reset while WVALID is still waiting.
      w_dly = 20;
      send(1'b1, 6'h0C, 32'h0000_0BAD);
      step();
      chk("rst_mid_pre_wvalid", {awvalid, wvalid}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 0);
      step(); step();
      rst_n = 1'b1;
      w_dly = 0;
      step();
      chk("rst_mid_cmd_ready_after", cmd_ready, 1);
      chk("rst_mid_no_rsp", rsp_valid, 0);
      send(1'b0, 6'h08, 32'h0);
      wait_rsp(1, c);
      chk("rst_rd_latency", c, 3);
      chk("rst_rd_rdata", rsp_rdata, 32'h1234);
      chk("rst_rd_write", rsp_write, 0);
      step();

      // DECERR read passes through with data.
      r_resp_k = 2'b11;
      send(1'b0, 6'h20, 32'h0);
      wait_rsp(1, c);
      chk("dec_latency", c, 3);
      chk("dec_resp", rsp_resp, 2'b11);
      chk("dec_rdata", rsp_rdata, 32'h0000_00A5);
      step();
      chk("dec_cmd_ready", cmd_ready, 1);
      r_resp_k = 2'b00;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tfhe_axil_master.md
TFHE_AXIL_MASTER -- requirements
Module: tfhe_axil_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, meaning AXI4-Lite data width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 6, meaning AXI4-Lite byte-address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, named M_AXI_ACLK and M_AXI_ARESETN.
REQ-004 Port M_AXI_ACLK, input, 1, the single clock.
REQ-005 Port M_AXI_ARESETN, input, 1, asynchronous active-low reset.
REQ-006 Ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-007 Ports cmd_write (input, 1), cmd_addr (input, ADDR), cmd_wdata (input, DATA) and cmd_wstrb (input, DATA/8): command type and payload; cmd_write 1=write, 0=read.
REQ-008 Ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-009 Ports rsp_write (output, 1), rsp_rdata (output, DATA) and rsp_resp (output, 2): completed-transaction type, read data and AXI response code.
REQ-010 Ports M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY} and M_AXI_R{DATA,RESP,VALID,READY}: the standard AXI4-Lite master channels.

Function
REQ-011 SHALL issue exactly one transaction at a time, with no outstanding overlap.
REQ-012 SHALL use FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP.
REQ-013 cmd_ready SHALL equal (state==IDLE); a command is accepted on cmd_valid&&cmd_ready and its payload is registered.
REQ-014 IDLE SHALL go to WR_REQ on an accepted write and to RD_REQ on an accepted read.
REQ-015 In the cycle after acceptance, write SHALL assert AWVALID and WVALID together, and read SHALL assert ARVALID; all outputs are registered.
REQ-016 In WR_REQ, AWVALID SHALL drop the cycle after its own AW handshake and WVALID after its own W handshake; each channel is tracked independently, in either order or simultaneously.
REQ-017 Once both AW and W handshakes are done, the FSM SHALL enter WR_RESP with BREADY=1; BREADY SHALL be 0 in all other states.
REQ-018 On BVALID&&BREADY, the block SHALL capture BRESP into rsp_resp, set rsp_write=1, drop BREADY and go to RSP.
REQ-019 In RD_REQ, ARVALID SHALL be held until ARREADY; after the handshake it drops and the FSM enters RD_DATA with RREADY=1.
REQ-020 On RVALID&&RREADY, the block SHALL capture RDATA and RRESP, set rsp_write=0, drop RREADY and go to RSP.
REQ-021 In RSP, rsp_valid SHALL be 1 and response fields stable until rsp_ready; then the FSM goes to IDLE.
REQ-022 A new command SHALL be accepted no earlier than the cycle after the rsp handshake.
REQ-023 Once asserted, any VALID SHALL NOT deassert and its payload SHALL NOT change before its READY.
REQ-024 AWADDR/ARADDR SHALL carry cmd_addr unmodified, and AWPROT/ARPROT SHALL be 3'b000.
REQ-025 Minimum latency with zero-wait slave SHALL be: accept at cycle 0, AW/W/AR valid at 1, B/R at 2, rsp_valid at 3.
REQ-026 For reads, rsp_rdata SHALL hold the last captured value; for writes, rsp_rdata SHALL be 0.
REQ-027 Response codes SHALL pass through unaltered, with no retry on SLVERR/DECERR.

Reset
REQ-028 Asserting M_AXI_ARESETN low SHALL immediately force state=IDLE, every VALID/READY output=0 (cmd_ready=0 while in reset), rsp_rdata=0, rsp_resp=2'b00, rsp_write=0 and address/data registers=0.
REQ-029 Reset mid-transaction SHALL abandon the transaction with no response produced; after release, cmd_ready=1 on the first clock.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10 and DECERR=2'b11.
REQ-031 No sub-module is required; a single flat module holds the FSM and the channel registers.

Verification
REQ-032 Write of addr 0x08, data 0x0000_1234, wstrb 0xF to a zero-wait slave -> AW/W valid at cycle 1, slave reg2=0x1234, rsp_valid at cycle 3 with resp=00 and rsp_write=1.
REQ-033 Write with AWREADY at cycle 1 and WREADY delayed to cycle 4 -> AWVALID low from cycle 2, WVALID held with stable data through cycle 4, BREADY only from cycle 5.
REQ-034 Read of addr 0x14 with slave returning 0xDEAD_BEEF and RVALID delayed 2 cycles -> rsp_rdata=0xDEADBEEF, rsp_write=0, resp=00.
REQ-035 Slave returns BRESP=2'b10 and rsp_ready is held low for 4 cycles -> rsp_valid stays high with resp=10 unchanged, cmd_ready stays 0 until the rsp handshake.
REQ-036 M_AXI_ARESETN pulsed low while in WR_REQ with WVALID pending -> all VALIDs drop asynchronously, no rsp_valid, and the next read completes normally.
